// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl: drives a bounded up/down counter through triangular
// sweeps lo->hi->lo with programmable dwell at each turning point.
// Optional build macro COUNT_CHECK_EN: abort the sweep with an error pulse
// when the fed-back count leaves the [lo, hi] window.
module counter_sweep_ctrl #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MIN_BOUND = 10,
    parameter int unsigned MAX_BOUND = 40,
    parameter int unsigned DW        = 4
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             start_in,
    input  logic             abort_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [DW-1:0]    dwell_in,
    input  logic [DW-1:0]    sweeps_in,
    input  logic [WIDTH-1:0] count_in,
    output logic             load_en_out,
    output logic [WIDTH-1:0] d_out,
    output logic             ahup_aldown_out,
    output logic             busy_out,
    output logic             done_out,
    output logic             err_out
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        UP       = 3'd2,
        DWELL_HI = 3'd3,
        DOWN     = 3'd4,
        DWELL_LO = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_BOUND);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_BOUND);

    state_t           state, state_next;
    logic [WIDTH-1:0] lo, lo_next, hi, hi_next;
    logic [WIDTH-1:0] lo_clamp, hi_clamp;
    logic [DW-1:0]    dwell, dwell_next;
    logic [DW-1:0]    sweeps, sweeps_next;
    logic [DW-1:0]    remain, remain_next;
    logic [DW-1:0]    dcnt, dcnt_next;
    logic             err_next;
    logic             at_hi, at_lo, out_of_range, checked_state;

    assign at_hi = (count_in == hi);
    assign at_lo = (count_in == lo);
    assign checked_state = (state == UP) || (state == DOWN) ||
                           (state == DWELL_HI) || (state == DWELL_LO);

`ifdef COUNT_CHECK_EN
    assign out_of_range = (count_in < lo) || (count_in > hi);
`else
    assign out_of_range = 1'b0;
`endif

    // Clamp requested bounds into the counter's legal range
    always_comb begin
        lo_clamp = lo_in;
        if (lo_in < MIN_V)      lo_clamp = MIN_V;
        else if (lo_in > MAX_V) lo_clamp = MAX_V;
        hi_clamp = hi_in;
        if (hi_in < MIN_V)      hi_clamp = MIN_V;
        else if (hi_in > MAX_V) hi_clamp = MAX_V;
    end

    // Next-state logic and counter-control decode (default is Hold)
    always_comb begin
        state_next      = state;
        lo_next         = lo;
        hi_next         = hi;
        dwell_next      = dwell;
        sweeps_next     = sweeps;
        remain_next     = remain;
        dcnt_next       = dcnt;
        err_next        = 1'b0;
        load_en_out     = 1'b1;
        d_out           = count_in;
        ahup_aldown_out = 1'b1;

        case (state)
            IDLE: begin
                if (start_in && !abort_in) begin
                    lo_next = lo_clamp;
                    hi_next = hi_clamp;
                    if (lo_clamp >= hi_clamp) begin
                        err_next = 1'b1;
                    end else begin
                        state_next  = LOAD;
                        dwell_next  = dwell_in;
                        sweeps_next = sweeps_in;
                        remain_next = sweeps_in;
                    end
                end
            end
            LOAD: begin
                d_out      = lo;
                state_next = UP;
            end
            UP: begin
                if (!at_hi) begin
                    load_en_out = 1'b0;
                end else if (dwell == '0) begin
                    state_next = DOWN;
                end else begin
                    state_next = DWELL_HI;
                    dcnt_next  = dwell;
                end
            end
            DWELL_HI: begin
                dcnt_next = dcnt - DW'(1);
                if (dcnt <= DW'(1)) state_next = DOWN;
            end
            DOWN: begin
                if (!at_lo) begin
                    load_en_out     = 1'b0;
                    ahup_aldown_out = 1'b0;
                end else begin
                    if (sweeps != '0) remain_next = remain - DW'(1);
                    if ((sweeps != '0) && (remain == DW'(1))) begin
                        state_next = DONE;
                    end else if (dwell == '0) begin
                        state_next = UP;
                    end else begin
                        state_next = DWELL_LO;
                        dcnt_next  = dwell;
                    end
                end
            end
            DWELL_LO: begin
                dcnt_next = dcnt - DW'(1);
                if (dcnt <= DW'(1)) state_next = UP;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (checked_state && out_of_range) begin
            state_next = IDLE;
            err_next   = 1'b1;
        end

        if ((state != IDLE) && abort_in) begin
            state_next = IDLE;
            err_next   = 1'b0;
        end
    end

    // State and sweep-parameter registers; status flags follow next state
    always_ff @(posedge clk or posedge reset_ah_in) begin
        if (reset_ah_in) begin
            state    <= IDLE;
            lo       <= '0;
            hi       <= '0;
            dwell    <= '0;
            sweeps   <= '0;
            remain   <= '0;
            dcnt     <= '0;
            busy_out <= 1'b0;
            done_out <= 1'b0;
            err_out  <= 1'b0;
        end else begin
            state    <= state_next;
            lo       <= lo_next;
            hi       <= hi_next;
            dwell    <= dwell_next;
            sweeps   <= sweeps_next;
            remain   <= remain_next;
            dcnt     <= dcnt_next;
            busy_out <= (state_next != IDLE);
            done_out <= (state_next == DONE);
            err_out  <= err_next;
        end
    end

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with a behavioural 10..40 counter.
module tb_counter_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start, abort;
    logic [7:0] lo, hi;
    logic [3:0] dwell, sweeps;
    logic [7:0] cnt;
    logic       load_en, dir, busy, done, err;
    logic [7:0] d;
    logic       force_en;
    logic [7:0] force_val;

    int checks = 0;
    int passes = 0;

    counter_sweep_ctrl dut (
        .clk             (clk),
        .reset_ah_in     (rst),
        .start_in        (start),
        .abort_in        (abort),
        .lo_in           (lo),
        .hi_in           (hi),
        .dwell_in        (dwell),
        .sweeps_in       (sweeps),
        .count_in        (cnt),
        .load_en_out     (load_en),
        .d_out           (d),
        .ahup_aldown_out (dir),
        .busy_out        (busy),
        .done_out        (done),
        .err_out         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bounded 10..40 up/down counter with wrap; force_en models a self-reset
    always_ff @(posedge clk) begin
        if (force_en)     cnt <= force_val;
        else if (load_en) cnt <= d;
        else if (dir)     cnt <= (cnt >= 8'd40) ? 8'd10 : cnt + 8'd1;
        else              cnt <= (cnt <= 8'd10) ? 8'd40 : cnt - 8'd1;
    end

    // Expected count on sample i of a single triangular sweep after LOAD
    function automatic logic [7:0] tri_val(input int l, input int h, input int dw, input int i);
        int n;
        n = h - l + 1;
        if (i < n) return 8'(l + i);
        if (i < n + dw + 1) return 8'(h);
        return 8'(h - (i - (n + dw + 1) + 1));
    endfunction

    task automatic do_start(input logic [7:0] l, input logic [7:0] h,
                            input logic [3:0] dw, input logic [3:0] sw);
        @(negedge clk);
        lo = l; hi = h; dwell = dw; sweeps = sw; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; force_en = 1'b1; force_val = 8'd10;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err, load_en, dir, d} !== {5'b00011, 8'd10})
            $display("FAIL reset_state: got %h want %h", {busy, done, err, load_en, dir, d}, {5'b00011, 8'd10});
        else passes++;
        rst = 1'b0; force_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, err, load_en, dir, cnt} !== {5'b00011, 8'd10})
            $display("FAIL idle_hold: got %h want %h", {busy, done, err, load_en, dir, cnt}, {5'b00011, 8'd10});
        else passes++;
    endtask

    task automatic test_reset_mid_up();
        logic found;
        found = 1'b0;
        do_start(8'd15, 8'd30, 4'd0, 4'd1);
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (cnt == 8'd20) found = 1'b1;
        end
        checks++;
        if (!found) $display("FAIL mid_up_reach20: got %0d want 20", cnt);
        else passes++;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err, load_en, dir, d} !== {5'b00011, 8'd20})
            $display("FAIL reset_mid_up: got %h want %h", {busy, done, err, load_en, dir, d}, {5'b00011, 8'd20});
        else passes++;
        @(negedge clk);
        checks++;
        if (cnt !== 8'd20) $display("FAIL reset_hold: got %0d want 20", cnt);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, load_en, cnt} !== {2'b01, 8'd20})
            $display("FAIL post_reset_idle: got %h want %h", {busy, load_en, cnt}, {2'b01, 8'd20});
        else passes++;
    endtask

    task automatic test_sweep();
        do_start(8'd12, 8'd15, 4'd2, 4'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({cnt, busy, done, err} !== {tri_val(12, 15, 2, i), 3'b100})
                $display("FAIL sweep_trace[%0d]: got %h want %h", i, {cnt, busy, done, err}, {tri_val(12, 15, 2, i), 3'b100});
            else passes++;
        end
        @(negedge clk);
        checks++;
        if ({cnt, busy, done} !== {8'd12, 2'b11})
            $display("FAIL sweep_done: got %h want %h", {cnt, busy, done}, {8'd12, 2'b11});
        else passes++;
        @(negedge clk);
        checks++;
        if ({cnt, busy, done} !== {8'd12, 2'b00})
            $display("FAIL sweep_idle: got %h want %h", {cnt, busy, done}, {8'd12, 2'b00});
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if ({cnt, load_en} !== {8'd12, 1'b1})
            $display("FAIL sweep_hold: got %h want %h", {cnt, load_en}, {8'd12, 1'b1});
        else passes++;
    endtask

    task automatic test_reject_clamp();
        do_start(8'd30, 8'd30, 4'd0, 4'd1);
        checks++;
        if ({err, busy} !== 2'b10) $display("FAIL reject_err: got %b want 10", {err, busy});
        else passes++;
        @(negedge clk);
        checks++;
        if ({err, busy, cnt} !== {2'b00, 8'd12})
            $display("FAIL reject_after: got %h want %h", {err, busy, cnt}, {2'b00, 8'd12});
        else passes++;
        do_start(8'd5, 8'd50, 4'd0, 4'd1);
        for (int i = 0; i < 62; i++) begin
            @(negedge clk);
            checks++;
            if ({cnt, busy, done, err} !== {tri_val(10, 40, 0, i), 3'b100})
                $display("FAIL clamp_trace[%0d]: got %h want %h", i, {cnt, busy, done, err}, {tri_val(10, 40, 0, i), 3'b100});
            else passes++;
        end
        @(negedge clk);
        checks++;
        if ({cnt, done} !== {8'd10, 1'b1})
            $display("FAIL clamp_done: got %h want %h", {cnt, done}, {8'd10, 1'b1});
        else passes++;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) $display("FAIL clamp_idle: got %b want 0", busy);
        else passes++;
    endtask

    task automatic test_continuous_abort();
        logic [7:0] tbl [6];
        tbl = '{8'd20, 8'd21, 8'd22, 8'd22, 8'd21, 8'd20};
        do_start(8'd20, 8'd22, 4'd0, 4'd0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            checks++;
            if ({cnt, busy, done} !== {tbl[i % 6], 2'b10})
                $display("FAIL cont_trace[%0d]: got %h want %h", i, {cnt, busy, done}, {tbl[i % 6], 2'b10});
            else passes++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({cnt, busy, done} !== {8'd20, 2'b00})
            $display("FAIL abort_idle: got %h want %h", {cnt, busy, done}, {8'd20, 2'b00});
        else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if ({cnt, done, load_en} !== {8'd20, 2'b01})
            $display("FAIL abort_frozen: got %h want %h", {cnt, done, load_en}, {8'd20, 2'b01});
        else passes++;
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        lo = 8'd20; hi = 8'd25; dwell = 4'd0; sweeps = 4'd1;
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        checks++;
        if ({busy, err, load_en, cnt} !== {3'b001, 8'd20})
            $display("FAIL start_abort: got %h want %h", {busy, err, load_en, cnt}, {3'b001, 8'd20});
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy, cnt} !== {1'b0, 8'd20})
            $display("FAIL start_abort_stay: got %h want %h", {busy, cnt}, {1'b0, 8'd20});
        else passes++;
    endtask

    task automatic test_start_ignored();
        do_start(8'd20, 8'd24, 4'd1, 4'd1);
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            checks++;
            if ({cnt, busy, done, err} !== {tri_val(20, 24, 1, i), 3'b100})
                $display("FAIL ignore_trace[%0d]: got %h want %h", i, {cnt, busy, done, err}, {tri_val(20, 24, 1, i), 3'b100});
            else passes++;
            if (i == 2) begin
                lo = 8'd10; hi = 8'd40; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ({cnt, done} !== {8'd20, 1'b1})
            $display("FAIL ignore_done: got %h want %h", {cnt, done}, {8'd20, 1'b1});
        else passes++;
        @(negedge clk);
        checks++;
        if ({busy, cnt} !== {1'b0, 8'd20})
            $display("FAIL ignore_idle: got %h want %h", {busy, cnt}, {1'b0, 8'd20});
        else passes++;
    endtask

    task automatic test_range_check();
        do_start(8'd20, 8'd30, 4'd0, 4'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (cnt !== 8'(20 + i)) $display("FAIL range_pre[%0d]: got %0d want %0d", i, cnt, 20 + i);
            else passes++;
        end
        force_en = 1'b1; force_val = 8'd10;
        @(negedge clk);
        force_en = 1'b0;
        checks++;
        if (cnt !== 8'd10) $display("FAIL range_forced: got %0d want 10", cnt);
        else passes++;
`ifdef COUNT_CHECK_EN
        @(negedge clk);
        checks++;
        if ({err, busy, done} !== 3'b100) $display("FAIL range_err: got %b want 100", {err, busy, done});
        else passes++;
        @(negedge clk);
        checks++;
        if ({err, busy, cnt} !== {2'b00, 8'd11})
            $display("FAIL range_idle: got %h want %h", {err, busy, cnt}, {2'b00, 8'd11});
        else passes++;
`else
        begin
            logic found, bad;
            found = 1'b0; bad = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (err || done) bad = 1'b1;
                if (cnt == 8'd30) found = 1'b1;
            end
            checks++;
            if ({found, bad} !== 2'b10) $display("FAIL range_nocheck_up: got %b want 10", {found, bad});
            else passes++;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (err) bad = 1'b1;
                if (done) found = 1'b1;
            end
            checks++;
            if ({found, bad, cnt} !== {2'b10, 8'd20})
                $display("FAIL range_nocheck_done: got %h want %h", {found, bad, cnt}, {2'b10, 8'd20});
            else passes++;
        end
`endif
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        lo = 8'd0; hi = 8'd0; dwell = 4'd0; sweeps = 4'd0;
        force_en = 1'b1; force_val = 8'd10;
        test_reset();
        test_reset_mid_up();
        test_sweep();
        test_reject_clamp();
        test_continuous_abort();
        test_start_abort_idle();
        test_start_ignored();
        test_range_check();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/counter_sweep_ctrl.md
Name: counter_sweep_ctrl

Overview:
- Sequencer for the bounded 8-bit up/down counter (range 10..40; ports load_en / d / up-down; count_out fed back here).
- Drives the counter through programmable triangular sweeps lo→hi→lo, with a dwell at each turning point and a sweep count.
- Holds the counter by reloading its current value, because the counter has no enable.
- Start/abort/busy/done control; sits between the host register block and the counter.

Parameters:
- WIDTH, 8, counter data width.
- MIN_BOUND, 10, lowest legal counter value.
- MAX_BOUND, 40, highest legal counter value.
- DW, 4, width of dwell and sweep-count fields.

Ports:
- clk  input  1  rising-edge clock.
- reset_ah_in  input  1  asynchronous active-high reset.
- start_in  input  1  single-cycle start request; sampled only in IDLE.
- abort_in  input  1  stop request; forces IDLE.
- lo_in  input  WIDTH  sweep low bound; sampled at start.
- hi_in  input  WIDTH  sweep high bound; sampled at start.
- dwell_in  input  DW  extra hold cycles at each turning point; sampled at start.
- sweeps_in  input  DW  number of full sweeps; 0 = run until abort; sampled at start.
- count_in  input  WIDTH  counter's count_out.
- load_en_out  output  1  counter load enable.
- d_out  output  WIDTH  counter load data.
- ahup_aldown_out  output  1  direction: 1 = up, 0 = down.
- busy_out  output  1  high in every state except IDLE.
- done_out  output  1  one-cycle pulse on normal completion.
- err_out  output  1  one-cycle pulse when a start or a check is rejected.

Behaviour:
- Interface: one clock (clk); reset_ah_in is asynchronous and active-high.
- Reset values: state=IDLE; all internal registers 0; busy_out=0, done_out=0, err_out=0.
- Counter-control outputs are decoded combinationally from the registered state and count_in.
  - "Hold" means load_en_out=1 and d_out=count_in, with ahup_aldown_out=1.
  - In reset and in IDLE the outputs are Hold.
- Start in IDLE:
  - lo and hi are each clamped to [MIN_BOUND, MAX_BOUND] and registered.
  - If clamped lo >= clamped hi: err_out pulses, state stays IDLE.
  - Otherwise: go to LOAD; remaining-sweep register = sweeps_in.
- LOAD: load_en_out=1, d_out=lo; next state UP. Count equals lo on the following cycle.
- UP: load_en_out=0, ahup_aldown_out=1, so the counter increments.
  - When count_in==hi: output Hold this cycle.
  - Then go to DWELL_HI with the dwell counter set to dwell_in, or go directly to DOWN if dwell_in=0.
- DWELL_HI: Hold; dwell counter decrements each cycle; go to DOWN in the cycle after the dwell counter reaches 1.
- DOWN: load_en_out=0, ahup_aldown_out=0.
  - When count_in==lo: Hold this cycle and end the sweep.
  - If sweeps_in≠0, decrement the remaining-sweep register; if it was 1, go to DONE.
  - Otherwise go to DWELL_LO, or directly to UP if dwell_in=0.
- DWELL_LO: mirror of DWELL_HI, exiting to UP.
- DONE: Hold; done_out=1 for this one cycle; next state IDLE.
- Turning-point timing: count_in equals hi (and each later lo) for exactly dwell_in+2 consecutive cycles.
- Full-scale sweeps: hi=MAX_BOUND and lo=MIN_BOUND are legal. The controller always stops the counter at the bound, so the counter's own wrap is never exercised.
- Abort (any non-IDLE state): next state IDLE; outputs are Hold from the next cycle; no done_out.
  - Abort together with start in IDLE: abort wins, start is ignored.
- start_in outside IDLE is ignored.
- Asynchronous reset in the middle of a sweep: immediate return to IDLE / reset values.

Optional Feature:
- Macro: COUNT_CHECK_EN.
- Defined: in UP, DOWN and the dwell states, if count_in < lo or count_in > hi (e.g. the counter self-reset to 10):
  - err_out pulses;
  - state goes to IDLE next cycle;
  - no done_out.
- Undefined: no range check. The controller relies solely on the equality compares, so an out-of-window count is counted until the equality compare is eventually met.

Test Plan:
- Reset asserted mid-UP with count 20 → busy_out=0 and Hold outputs immediately; after release, start with lo=12, hi=15 runs normally.
- lo=12, hi=15, dwell=2, sweeps=1, counter model attached → count trace 12,13,14,15×4,14,13,12, then done_out one cycle and busy_out=0; 12 is held afterwards.
- lo=30, hi=30 → err_out pulses one cycle, busy_out stays 0. lo=5, hi=50 → clamped to 10..40; a full sweep to 40 and back to 10 completes.
- sweeps=0, lo=20, hi=22, dwell=0 → continuous 20,21,22,22,21,20,20,21… ; abort_in while in DOWN → IDLE next cycle, count frozen, no done_out.
- start_in and abort_in asserted together in IDLE → stays IDLE, busy_out=0. start_in pulsed during UP → ignored, trace unchanged.
- COUNT_CHECK_EN defined, counter forced to 10 during a 20..30 sweep → err_out pulse, IDLE. Macro undefined → no err_out; up-count continues from 10 until it reaches 30.
